// File: rtl/adder_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package adder_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Byte index width: enough to count NBYTES bytes, never narrower than 1 bit.
  function automatic int idx_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction
endpackage

// File: rtl/byte_adder_ci.sv
// 8-bit ripple-carry byte slice; also exposes the carry into bit 7 for
// signed-overflow detection on the most significant byte.
module byte_adder_ci
  import adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              c_out,
  output logic              c7
);
  logic [BYTE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_fadder
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[BYTE_W];
  assign c7    = c[BYTE_W - 1];
endmodule

// File: rtl/serial_wide_adder.sv
// Byte-serial wide adder: adds two NBYTES-byte operands LSB byte first through
// one shared 8-bit slice, holding the result until the consumer takes it.
module serial_wide_adder
  import adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum_out,
  output logic                  c_out,
  output logic                  ovf
);
  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_w(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      a_sh, b_sh, sum_sh, sum_nx;
  logic              carry_q, c7_q, out_valid_q;
  logic [BYTE_W-1:0] byte_sum;
  logic              byte_co, byte_c7;
  logic              accept, last;

  byte_adder_ci u_slice (
    .a     (a_sh[BYTE_W-1:0]),
    .b     (b_sh[BYTE_W-1:0]),
    .cin   (carry_q),
    .sum   (byte_sum),
    .c_out (byte_co),
    .c7    (byte_c7)
  );

  assign last     = (idx == LAST);
  // A new op may load in the same cycle the previous result is taken.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign sum_nx   = W'({byte_sum, sum_sh} >> BYTE_W);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = in_valid ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry_q     <= 1'b0;
      c7_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_sh    <= a_in;
        b_sh    <= b_in;
        carry_q <= cin;
        idx     <= '0;
      end else if (state == RUN) begin
        a_sh    <= a_sh >> BYTE_W;
        b_sh    <= b_sh >> BYTE_W;
        sum_sh  <= sum_nx;
        carry_q <= byte_co;
        if (last) c7_q <= byte_c7;
        else      idx  <= idx + 1'b1;
      end
      out_valid_q <= ((state == RUN) && last) || (out_valid_q && !out_ready);
    end
  end

  assign out_valid = out_valid_q;
  assign sum_out   = sum_sh;
  assign c_out     = carry_q;
  assign ovf       = c7_q ^ carry_q;
endmodule

// File: tb/tb_serial_wide_adder.sv
// Bench for serial_wide_adder: NBYTES=4 and NBYTES=1 instances against a
// plain-arithmetic transaction model, plus directed literal cases.
module tb_serial_wide_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic        out_ready[2];
  logic        cin      [2];
  logic [31:0] a_in     [2];
  logic [31:0] b_in     [2];

  logic        ir4, ov4, c4, f4;
  logic [31:0] s4;
  logic        ir1, ov1, c1, f1;
  logic [7:0]  s1;

  serial_wide_adder #(.NBYTES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir4),
    .a_in(a_in[0]), .b_in(b_in[0]), .cin(cin[0]),
    .out_valid(ov4), .out_ready(out_ready[0]),
    .sum_out(s4), .c_out(c4), .ovf(f4)
  );

  serial_wide_adder #(.NBYTES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir1),
    .a_in(a_in[1][7:0]), .b_in(b_in[1][7:0]), .cin(cin[1]),
    .out_valid(ov1), .out_ready(out_ready[1]),
    .sum_out(s1), .c_out(c1), .ovf(f1)
  );

  int          nb[2] = '{4, 1};
  bit          busy[2];
  int          due[2];
  logic [33:0] exp_res[2];
  bit          acc[2], take[2];
  int          taken[2];
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;

  // {ovf, carry, sum} of an n-byte add, from the integer sum and sign rule.
  function automatic logic [33:0] ref_add(input int n, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci);
    int          w;
    logic [32:0] mask, full;
    logic [31:0] s;
    logic        c, o;
    w    = 8 * n;
    mask = (33'd1 << w) - 33'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, ci};
    s    = full[31:0] & mask[31:0];
    c    = full[w];
    o    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {o, c, s};
  endfunction

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare both DUTs with the model at negedge, advance model at posedge.
  task automatic tick();
    logic [31:0] sa;
    logic        ca, fa, ira, ova, exp_ov, exp_ir;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      acc[d]  = 1'b0;
      take[d] = 1'b0;
      if (rst) continue;
      if (d == 0) begin sa = s4; ca = c4; fa = f4; ira = ir4; ova = ov4; end
      else begin sa = {24'd0, s1}; ca = c1; fa = f1; ira = ir1; ova = ov1; end
      exp_ov = busy[d] && (cyc >= due[d]);
      exp_ir = !busy[d] || (exp_ov && out_ready[d]);
      chk($sformatf("n%0d out_valid", nb[d]), ova, exp_ov);
      chk($sformatf("n%0d in_ready", nb[d]), ira, exp_ir);
      if (exp_ov) begin
        chk($sformatf("n%0d sum", nb[d]), sa, exp_res[d][31:0]);
        chk($sformatf("n%0d c_out", nb[d]), ca, exp_res[d][32]);
        chk($sformatf("n%0d ovf", nb[d]), fa, exp_res[d][33]);
      end
      acc[d]  = in_valid[d] && exp_ir;
      take[d] = exp_ov && out_ready[d];
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) busy[d] = 1'b0;
      else begin
        if (take[d]) begin busy[d] = 1'b0; taken[d]++; end
        if (acc[d]) begin
          busy[d]    = 1'b1;
          due[d]     = cyc + nb[d];
          exp_res[d] = ref_add(nb[d], a_in[d], b_in[d], cin[d]);
        end
      end
    end
    #1;
  endtask

  task automatic start4(input logic [31:0] a, input logic [31:0] b, input logic ci);
    a_in[0] = a; b_in[0] = b; cin[0] = ci; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
  endtask

  task automatic wait4(input string name, input int exp_lat);
    int k = 0;
    do begin tick(); k++; end while (!ov4 && k < 20);
    chk({name, " latency"}, k, exp_lat);
  endtask

  task automatic expect4(input string name, input logic [31:0] s, input logic c, input logic o);
    chk({name, " sum"}, s4, s);
    chk({name, " c_out"}, c4, c);
    chk({name, " ovf"}, f4, o);
  endtask

  task automatic take4();
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
  endtask

  initial begin
    int budget;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; cin[d] = 1'b0;
      a_in[d] = '0; b_in[d] = '0; busy[d] = 1'b0; taken[d] = 0;
    end
    out_ready[1] = 1'b1;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset in_ready", ir4, 1'b1);
    chk("reset out_valid", ov4, 1'b0);
    chk("reset sum", s4, 32'd0);
    chk("reset c_out", c4, 1'b0);
    chk("reset ovf", f4, 1'b0);
    chk("reset n1 in_ready", ir1, 1'b1);

    chk("model carry wrap", ref_add(4, 32'hFFFF_FFFF, 32'h1, 1'b0), {1'b0, 1'b1, 32'h0});
    chk("model pos ovf", ref_add(4, 32'h7FFF_FFFF, 32'h0, 1'b1), {1'b1, 1'b0, 32'h8000_0000});
    chk("model n1", ref_add(1, 32'h7F, 32'h01, 1'b0), {1'b1, 1'b0, 32'h80});

    start4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait4("wrap", 4);
    expect4("wrap", 32'h0, 1'b1, 1'b0);
    take4();

    start4(32'h7FFF_FFFF, 32'h0, 1'b1);
    wait4("posovf", 4);
    expect4("posovf", 32'h8000_0000, 1'b0, 1'b1);
    take4();
    start4(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait4("negovf", 4);
    expect4("negovf", 32'h0, 1'b1, 1'b1);
    take4();

    start4(32'h0123_4567, 32'h89AB_CDEF, 1'b0);
    wait4("bp", 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp out_valid", ov4, 1'b1);
      chk("bp in_ready", ir4, 1'b0);
      expect4("bp", 32'h8ACF_1356, 1'b0, 1'b0);
    end
    a_in[0] = 32'h5; b_in[0] = 32'h3; cin[0] = 1'b1;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    #1;
    chk("bp in_ready on take", ir4, 1'b1);
    tick();
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    wait4("bp next", 4);
    expect4("bp next", 32'h9, 1'b0, 1'b0);
    take4();

    start4(32'h1111_1111, 32'h2222_2222, 1'b0);
    a_in[0] = 32'h1234_5678; b_in[0] = 32'h1234_5678; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    wait4("ignore", 3);
    expect4("ignore", 32'h3333_3333, 1'b0, 1'b0);
    take4();

    start4(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun in_ready", ir4, 1'b1);
    chk("midrun out_valid", ov4, 1'b0);
    expect4("midrun", 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrun stale", ov4, 1'b0);
    end

    taken[0] = 0; taken[1] = 0;
    budget = 0;
    while ((taken[0] < 1000 || taken[1] < 1000) && budget < 30000) begin
      for (int d = 0; d < 2; d++) begin
        if (acc[d]) in_valid[d] = 1'b0;
        if (!in_valid[d] && $urandom_range(3) != 0) begin
          if ($urandom_range(7) == 0) begin
            a_in[d] = ($urandom_range(1) != 0) ? 32'h7FFF_FF7F : 32'hFFFF_FFFF;
            b_in[d] = ($urandom_range(1) != 0) ? 32'h8000_0080 : 32'h0000_0001;
          end else begin
            a_in[d] = $urandom;
            b_in[d] = $urandom;
          end
          cin[d]      = 1'($urandom_range(1));
          in_valid[d] = 1'b1;
        end
        out_ready[d] = ($urandom_range(3) != 0);
      end
      tick();
      budget++;
    end
    chk("random n4 completed", taken[0] >= 1000, 1'b1);
    chk("random n1 completed", taken[1] >= 1000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
